// File: rtl/pcap_byte_deframer.sv
`default_nettype none
// ============================================================================
// Module  : pcap_byte_deframer
// Purpose : Parses a raw pcap file arriving one byte per handshake (global
//           header, then record header + payload repeated) and repacks each
//           packet payload into OUT_BYTES-wide AXI-Stream beats with
//           TKEEP/TLAST. Backpressure from the consumer propagates to the
//           byte source.
// Ports   : CLK, RST (async, active high)
//           S_TVALID/S_TREADY/S_TDATA[7:0]   pcap byte stream in
//           M_TVALID/M_TREADY/M_TDATA/M_TKEEP/M_TLAST  packed packet beats
//           M_TUSER[63:0] {ts_sec, ts_usec}  (only with PCAP_TS_OUT_EN)
//           PKT_COUNT  packets fully delivered (wraps)
//           ERR_MAGIC  sticky, bad global magic
//           ERR_LEN    sticky, incl_len above MAX_PKT_LEN
// Option  : define PCAP_TS_OUT_EN to add the M_TUSER timestamp port.
// Rev     : 1.0 - initial release
// ============================================================================
module pcap_byte_deframer #(
    parameter int OUT_BYTES   = 16,
    parameter int MAX_PKT_LEN = 16384,
    parameter int CNT_W       = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   S_TVALID,
    output logic                   S_TREADY,
    input  logic [7:0]             S_TDATA,
    output logic                   M_TVALID,
    input  logic                   M_TREADY,
    output logic [8*OUT_BYTES-1:0] M_TDATA,
    output logic [OUT_BYTES-1:0]   M_TKEEP,
    output logic                   M_TLAST,
`ifdef PCAP_TS_OUT_EN
    output logic [63:0]            M_TUSER,
`endif
    output logic [CNT_W-1:0]       PKT_COUNT,
    output logic                   ERR_MAGIC,
    output logic                   ERR_LEN
);

    localparam int c_FILL_W = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
    localparam int c_REM_W  = $clog2(MAX_PKT_LEN + 1);

    localparam logic [c_FILL_W-1:0] c_LAST_LANE = c_FILL_W'(OUT_BYTES - 1);
    localparam logic [c_FILL_W-1:0] c_FILL_ONE  = c_FILL_W'(1);
    localparam logic [c_REM_W-1:0]  c_REM_ONE   = c_REM_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] c_GHDR = 2'd0;
    localparam logic [1:0] c_RHDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_HALT = 2'd3;

    logic [1:0]             r_state;
    logic [4:0]             r_hdr_cnt;
    logic                   r_le;
    logic [31:0]            r_shift;
    logic [31:0]            r_incl;
    logic [c_REM_W-1:0]     r_remain;
    logic [c_FILL_W-1:0]    r_fill;
    logic [8*OUT_BYTES-1:0] r_asm;
    logic                   r_m_valid;
    logic [8*OUT_BYTES-1:0] r_m_data;
    logic [OUT_BYTES-1:0]   r_m_keep;
    logic                   r_m_last;
    logic [CNT_W-1:0]       r_pkt_count;
    logic                   r_err_magic;
    logic                   r_err_len;
`ifdef PCAP_TS_OUT_EN
    logic [31:0]            r_ts_sec;
    logic [31:0]            r_ts_usec;
    logic [63:0]            r_m_user;
`endif

    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_last;
    logic                   w_complete;
    logic [31:0]            w_shift_be;
    logic [31:0]            w_shift_le;
    logic [31:0]            w_shift_next;
    logic                   w_magic_le;
    logic                   w_magic_be;
    logic [8*OUT_BYTES-1:0] w_asm_next;
    logic [OUT_BYTES-1:0]   w_keep_next;

    assign w_in_fire  = S_TVALID && S_TREADY;
    assign w_out_fire = r_m_valid && M_TREADY;
    assign w_last     = (r_remain == c_REM_ONE);
    assign w_complete = (r_fill == c_LAST_LANE) || w_last;

    // Fields are assembled in a shift register: big-endian shifts bytes in
    // from the bottom, little-endian from the top, so after four bytes the
    // register holds the decoded value either way.
    assign w_shift_be   = {r_shift[23:0], S_TDATA};
    assign w_shift_le   = {S_TDATA, r_shift[31:8]};
    assign w_shift_next = r_le ? w_shift_le : w_shift_be;

    // Magic compared in file byte order (both micro- and nanosecond forms).
    assign w_magic_le = (w_shift_be == 32'hD4C3_B2A1) || (w_shift_be == 32'h4D3C_B2A1);
    assign w_magic_be = (w_shift_be == 32'hA1B2_C3D4) || (w_shift_be == 32'hA1B2_3C4D);

    // Only a word-completing byte needs the output register, so the source
    // is stalled just when that byte would overwrite an unaccepted beat.
    assign S_TREADY = (r_state != c_DATA) || !(w_complete && r_m_valid && !M_TREADY);

    always_comb begin
        w_asm_next  = r_asm;
        w_keep_next = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (r_fill == c_FILL_W'(i)) begin
                w_asm_next[8*i +: 8] = S_TDATA;
            end
            w_keep_next[i] = (c_FILL_W'(i) <= r_fill);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= c_GHDR;
            r_hdr_cnt   <= '0;
            r_le        <= 1'b1;
            r_shift     <= '0;
            r_incl      <= '0;
            r_remain    <= '0;
            r_fill      <= '0;
            r_asm       <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_keep    <= '0;
            r_m_last    <= 1'b0;
            r_pkt_count <= '0;
            r_err_magic <= 1'b0;
            r_err_len   <= 1'b0;
`ifdef PCAP_TS_OUT_EN
            r_ts_sec    <= '0;
            r_ts_usec   <= '0;
            r_m_user    <= '0;
`endif
        end else begin
            if (w_out_fire) begin
                r_m_valid <= 1'b0;
                if (r_m_last) begin
                    r_pkt_count <= r_pkt_count + c_CNT_ONE;
                end
            end

            if (w_in_fire) begin
                case (r_state)
                    c_GHDR: begin
                        r_shift   <= w_shift_be;
                        r_hdr_cnt <= r_hdr_cnt + 5'd1;
                        if (r_hdr_cnt == 5'd3) begin
                            if (w_magic_le) begin
                                r_le <= 1'b1;
                            end else if (w_magic_be) begin
                                r_le <= 1'b0;
                            end else begin
                                r_err_magic <= 1'b1;
                                r_state     <= c_HALT;
                            end
                        end
                        if (r_hdr_cnt == 5'd23) begin
                            r_hdr_cnt <= '0;
                            r_state   <= c_RHDR;
                        end
                    end

                    c_RHDR: begin
                        r_shift   <= w_shift_next;
                        r_hdr_cnt <= r_hdr_cnt + 5'd1;
`ifdef PCAP_TS_OUT_EN
                        if (r_hdr_cnt == 5'd3) begin
                            r_ts_sec <= w_shift_next;
                        end
                        if (r_hdr_cnt == 5'd7) begin
                            r_ts_usec <= w_shift_next;
                        end
`endif
                        if (r_hdr_cnt == 5'd11) begin
                            r_incl <= w_shift_next;
                        end
                        if (r_hdr_cnt == 5'd15) begin
                            r_hdr_cnt <= '0;
                            // Zero-length records are skipped silently.
                            if (r_incl > 32'(MAX_PKT_LEN)) begin
                                r_err_len <= 1'b1;
                                r_state   <= c_HALT;
                            end else if (r_incl != 32'd0) begin
                                r_remain <= r_incl[c_REM_W-1:0];
                                r_fill   <= '0;
                                r_asm    <= '0;
                                r_state  <= c_DATA;
                            end
                        end
                    end

                    c_DATA: begin
                        r_remain <= r_remain - c_REM_ONE;
                        if (w_complete) begin
                            // Lanes above fill are still zero from the last clear.
                            r_m_valid <= 1'b1;
                            r_m_data  <= w_asm_next;
                            r_m_keep  <= w_keep_next;
                            r_m_last  <= w_last;
`ifdef PCAP_TS_OUT_EN
                            r_m_user  <= {r_ts_sec, r_ts_usec};
`endif
                            r_fill    <= '0;
                            r_asm     <= '0;
                        end else begin
                            r_asm  <= w_asm_next;
                            r_fill <= r_fill + c_FILL_ONE;
                        end
                        if (w_last) begin
                            r_state <= c_RHDR;
                        end
                    end

                    default: begin
                        // HALT: input is swallowed until reset.
                    end
                endcase
            end
        end
    end

    assign M_TVALID  = r_m_valid;
    assign M_TDATA   = r_m_data;
    assign M_TKEEP   = r_m_keep;
    assign M_TLAST   = r_m_last;
    assign PKT_COUNT = r_pkt_count;
    assign ERR_MAGIC = r_err_magic;
    assign ERR_LEN   = r_err_len;
`ifdef PCAP_TS_OUT_EN
    assign M_TUSER   = r_m_user;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcap_byte_deframer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_pcap_byte_deframer
// Purpose : Self-checking bench for pcap_byte_deframer. Builds pcap byte
//           streams, predicts the output beats by chopping each payload into
//           OUT_BYTES chunks, and compares every accepted beat.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_pcap_byte_deframer;

    localparam int OB   = 16;
    localparam int MAXL = 16384;
    localparam int CW   = 32;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            S_TVALID = 1'b0;
    logic            S_TREADY;
    logic [7:0]      S_TDATA = 8'h00;
    logic            M_TVALID;
    logic            M_TREADY = 1'b1;
    logic [8*OB-1:0] M_TDATA;
    logic [OB-1:0]   M_TKEEP;
    logic            M_TLAST;
`ifdef PCAP_TS_OUT_EN
    logic [63:0]     M_TUSER;
`endif
    logic [CW-1:0]   PKT_COUNT;
    logic            ERR_MAGIC;
    logic            ERR_LEN;

    pcap_byte_deframer #(
        .OUT_BYTES  (OB),
        .MAX_PKT_LEN(MAXL),
        .CNT_W      (CW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .S_TVALID (S_TVALID),
        .S_TREADY (S_TREADY),
        .S_TDATA  (S_TDATA),
        .M_TVALID (M_TVALID),
        .M_TREADY (M_TREADY),
        .M_TDATA  (M_TDATA),
        .M_TKEEP  (M_TKEEP),
        .M_TLAST  (M_TLAST),
`ifdef PCAP_TS_OUT_EN
        .M_TUSER  (M_TUSER),
`endif
        .PKT_COUNT(PKT_COUNT),
        .ERR_MAGIC(ERR_MAGIC),
        .ERR_LEN  (ERR_LEN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [8*OB-1:0] data;
        logic [OB-1:0]   keep;
        logic            last;
        logic [63:0]     user;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      obs_q[$];
    logic [7:0] tx_q[$];

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  gap_en = 1'b0;
    int  rdy_mode = 0;
    int  rdy_cyc = 0;
    bit  mon_en = 1'b0;
    bit  saw_valid = 1'b0;
    bit  prev_stall = 1'b0;
    beat_t prev_beat;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: a packet of len bytes (value start+k) becomes ceil(len/OB)
    // beats; byte k sits in lane k%OB of beat k/OB, TLAST on the final one.
    task automatic exp_pkt(input int len, input logic [7:0] start, input logic [63:0] ts);
        for (int off = 0; off < len; off += OB) begin
            beat_t b;
            b.data = '0;
            b.keep = '0;
            for (int i = 0; i < OB; i++) begin
                if (off + i < len) begin
                    b.data[8*i +: 8] = 8'(start + off + i);
                    b.keep[i] = 1'b1;
                end
            end
            b.last = (off + OB >= len);
            b.user = ts;
            exp_q.push_back(b);
        end
    endtask

    task automatic put32(input logic [31:0] v, input bit le);
        if (le) begin
            tx_q.push_back(v[7:0]);   tx_q.push_back(v[15:8]);
            tx_q.push_back(v[23:16]); tx_q.push_back(v[31:24]);
        end else begin
            tx_q.push_back(v[31:24]); tx_q.push_back(v[23:16]);
            tx_q.push_back(v[15:8]);  tx_q.push_back(v[7:0]);
        end
    endtask

    // magic is given in file byte order
    task automatic add_ghdr(input logic [31:0] magic, input bit le);
        put32(magic, 1'b0);
        put32(32'h0004_0002, le);
        put32(32'h0, le);
        put32(32'h0, le);
        put32(32'h0000_FFFF, le);
        put32(32'h1, le);
    endtask

    task automatic add_rec(input bit le, input logic [31:0] tsec, input logic [31:0] tusec,
                           input logic [31:0] incl, input int paylen, input logic [7:0] start);
        put32(tsec, le);
        put32(tusec, le);
        put32(incl, le);
        put32(incl, le);
        for (int k = 0; k < paylen; k++) tx_q.push_back(8'(start + k));
    endtask

    task automatic send_all;
        while (tx_q.size() > 0) begin
            logic [7:0] b;
            int t;
            bit done;
            b = tx_q.pop_front();
            if (gap_en) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    S_TVALID = 1'b0;
                    @(posedge CLK); #1;
                end
            end
            S_TVALID = 1'b1;
            S_TDATA  = b;
            done = 1'b0;
            t = 0;
            while (!done && t < 1000) begin
                @(negedge CLK);
                if (S_TREADY === 1'b1) done = 1'b1;
                @(posedge CLK); #1;
                t++;
            end
            if (!done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: byte %0h not accepted, S_TREADY=%b required 1", b, S_TREADY);
            end
        end
        S_TVALID = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 5000) begin
            @(posedge CLK);
            t++;
        end
        repeat (2) @(posedge CLK);
        #1;
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic do_reset;
        S_TVALID = 1'b0;
        #2 RST = 1'b1;
        #1;
        chk("rst_m_tvalid", M_TVALID, 0);
        chk("rst_m_tdata", M_TDATA, 0);
        chk("rst_m_tkeep", M_TKEEP, 0);
        chk("rst_m_tlast", M_TLAST, 0);
        chk("rst_pkt_count", PKT_COUNT, 0);
        chk("rst_err_magic", ERR_MAGIC, 0);
        chk("rst_err_len", ERR_LEN, 0);
        repeat (2) @(posedge CLK);
        #3 RST = 1'b0;
        @(posedge CLK); #1;
        chk("rst_s_tready", S_TREADY, 1);
        exp_q.delete();
        obs_q.delete();
        saw_valid = 1'b0;
        mon_en = 1'b1;
    endtask

    // consumer ready pattern
    initial begin
        forever begin
            @(posedge CLK); #1;
            rdy_cyc++;
            M_TREADY = (rdy_mode == 0) ? 1'b1 : ((rdy_cyc % 3) == 0);
        end
    end

    // output compare process
    always @(negedge CLK) begin
        beat_t cur;
        cur.data = M_TDATA;
        cur.keep = M_TKEEP;
        cur.last = M_TLAST;
`ifdef PCAP_TS_OUT_EN
        cur.user = M_TUSER;
`else
        cur.user = 64'h0;
`endif
        if (RST || !mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", M_TVALID, 1);
                chk("stall_data", cur.data, prev_beat.data);
                chk("stall_keep", cur.keep, prev_beat.keep);
                chk("stall_last", cur.last, prev_beat.last);
            end
            if (M_TVALID === 1'b1) saw_valid = 1'b1;
            if (M_TVALID === 1'b1 && M_TREADY === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: data=%0h keep=%0h last=%b, required no beat",
                             cur.data, cur.keep, cur.last);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", cur.data, e.data);
                    chk("beat_keep", cur.keep, e.keep);
                    chk("beat_last", cur.last, e.last);
`ifdef PCAP_TS_OUT_EN
                    chk("beat_user", cur.user, e.user);
`endif
                end
                obs_q.push_back(cur);
            end
            if (S_TREADY !== 1'b1) begin
                chk("s_tready_low_only_when_blocked", {M_TVALID, M_TREADY}, 2'b10);
            end
            prev_stall = (M_TVALID === 1'b1) && (M_TREADY !== 1'b1);
            prev_beat  = cur;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // T1: LE, one 64-byte record
        do_reset();
        add_ghdr(32'hD4C3_B2A1, 1'b1);
        add_rec(1'b1, 32'h5F00_0001, 32'h0000_0011, 32'd64, 64, 8'h00);
        exp_pkt(64, 8'h00, {32'h5F00_0001, 32'h0000_0011});
        send_all();
        wait_drain("t1_drain");
        chk("t1_pkt_count", PKT_COUNT, 1);
        chk("t1_beats", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            chk("t1_b0_keep", obs_q[0].keep, 16'hFFFF);
            chk("t1_b0_lane0", obs_q[0].data[7:0], 8'h00);
            chk("t1_b0_lane15", obs_q[0].data[127:120], 8'h0F);
            chk("t1_b0_last", obs_q[0].last, 0);
            chk("t1_b3_last", obs_q[3].last, 1);
        end

        // T2: 17-byte then 16-byte records
        do_reset();
        add_ghdr(32'hD4C3_B2A1, 1'b1);
        add_rec(1'b1, 32'h1, 32'h2, 32'd17, 17, 8'h00);
        add_rec(1'b1, 32'h3, 32'h4, 32'd16, 16, 8'h80);
        exp_pkt(17, 8'h00, {32'h1, 32'h2});
        exp_pkt(16, 8'h80, {32'h3, 32'h4});
        send_all();
        wait_drain("t2_drain");
        chk("t2_pkt_count", PKT_COUNT, 2);
        chk("t2_beats", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            chk("t2_b0_keep", obs_q[0].keep, 16'hFFFF);
            chk("t2_b1_keep", obs_q[1].keep, 16'h0001);
            chk("t2_b1_last", obs_q[1].last, 1);
            chk("t2_b1_data", obs_q[1].data, 128'h10);
            chk("t2_b2_keep", obs_q[2].keep, 16'hFFFF);
            chk("t2_b2_lane0", obs_q[2].data[7:0], 8'h80);
        end

        // T3: big-endian, 40-byte packet
        do_reset();
        add_ghdr(32'hA1B2_C3D4, 1'b0);
        add_rec(1'b0, 32'h0102_0304, 32'h0A0B_0C0D, 32'h0000_0028, 40, 8'h40);
        exp_pkt(40, 8'h40, {32'h0102_0304, 32'h0A0B_0C0D});
        send_all();
        wait_drain("t3_drain");
        chk("t3_pkt_count", PKT_COUNT, 1);
        chk("t3_beats", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            chk("t3_b2_keep", obs_q[2].keep, 16'h00FF);
            chk("t3_b2_last", obs_q[2].last, 1);
            chk("t3_b2_lane7", obs_q[2].data[63:56], 8'h67);
`ifdef PCAP_TS_OUT_EN
            chk("t3_b0_user", obs_q[0].user, 64'h0102_0304_0A0B_0C0D);
            chk("t3_b2_user", obs_q[2].user, 64'h0102_0304_0A0B_0C0D);
`endif
        end

        // T4: 200 bytes with throttled consumer and bursty source
        do_reset();
        rdy_mode = 1;
        gap_en   = 1'b1;
        add_ghdr(32'h4D3C_B2A1, 1'b1);
        add_rec(1'b1, 32'h77, 32'h88, 32'd200, 200, 8'h10);
        exp_pkt(200, 8'h10, {32'h77, 32'h88});
        send_all();
        wait_drain("t4_drain");
        chk("t4_pkt_count", PKT_COUNT, 1);
        chk("t4_beats", obs_q.size(), 13);
        if (obs_q.size() == 13) begin
            chk("t4_b12_keep", obs_q[12].keep, 16'h00FF);
        end
        rdy_mode = 0;
        gap_en   = 1'b0;

        // T5: bad magic, then reset mid-stream and a good file
        do_reset();
        tx_q.push_back(8'hDE); tx_q.push_back(8'hAD); tx_q.push_back(8'hBE);
        send_all();
        chk("t5_err_magic_before_byte3", ERR_MAGIC, 0);
        tx_q.push_back(8'hEF);
        send_all();
        chk("t5_err_magic", ERR_MAGIC, 1);
        for (int k = 0; k < 30; k++) tx_q.push_back(8'(k));
        send_all();
        chk("t5_halt_s_tready", S_TREADY, 1);
        chk("t5_err_magic_sticky", ERR_MAGIC, 1);
        chk("t5_no_valid", saw_valid, 0);
        do_reset();
        add_ghdr(32'hD4C3_B2A1, 1'b1);
        add_rec(1'b1, 32'h9, 32'hA, 32'd5, 5, 8'h33);
        exp_pkt(5, 8'h33, {32'h9, 32'hA});
        send_all();
        wait_drain("t5_drain");
        chk("t5_pkt_count", PKT_COUNT, 1);
        chk("t5_beats", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            chk("t5_b0_keep", obs_q[0].keep, 16'h001F);
            chk("t5_b0_data", obs_q[0].data, 128'h37_3635_3433);
        end

        // T6: zero-length record, 8-byte record, oversize record
        do_reset();
        add_ghdr(32'hD4C3_B2A1, 1'b1);
        add_rec(1'b1, 32'h1, 32'h1, 32'd0, 0, 8'h00);
        add_rec(1'b1, 32'h2, 32'h2, 32'd8, 8, 8'hA0);
        add_rec(1'b1, 32'h3, 32'h3, 32'(MAXL + 1), 0, 8'h00);
        exp_pkt(8, 8'hA0, {32'h2, 32'h2});
        send_all();
        wait_drain("t6_drain");
        chk("t6_err_len", ERR_LEN, 1);
        chk("t6_err_magic", ERR_MAGIC, 0);
        for (int k = 0; k < 40; k++) tx_q.push_back(8'(k + 1));
        send_all();
        repeat (3) @(posedge CLK);
        #1;
        chk("t6_pkt_count", PKT_COUNT, 1);
        chk("t6_beats", obs_q.size(), 1);
        chk("t6_halt_s_tready", S_TREADY, 1);
        chk("t6_halt_no_valid", M_TVALID, 0);
        if (obs_q.size() == 1) begin
            chk("t6_b0_keep", obs_q[0].keep, 16'h00FF);
            chk("t6_b0_last", obs_q[0].last, 1);
            chk("t6_b0_data", obs_q[0].data, 128'hA7A6_A5A4_A3A2_A1A0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
